// File: rtl/knn_sort_ctrl.sv
// Frame sequencer for the bitonic distance sorter: collects up to N distance/type
// pairs, launches the sorter, and streams the K nearest results downstream.
module knn_sort_ctrl #(
  parameter int L      = 3,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_dist,
  input  logic [TYPE_W-1:0]       in_type,
  input  logic                    in_last,
  output logic                    sort_in_valid,
  output logic                    sort_ascending,
  output logic [W*(1<<L)-1:0]     sort_in,
  output logic [TYPE_W*(1<<L)-1:0] sort_in_type,
  input  logic [W*(1<<L)-1:0]     sort_out,
  input  logic [TYPE_W*(1<<L)-1:0] sort_out_type,
  input  logic                    sort_out_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_dist,
  output logic [TYPE_W-1:0]       out_type,
  output logic                    out_last,
  output logic                    trunc_err,
  output logic                    busy
);

  localparam int N = 1 << L;

  typedef enum logic [2:0] {COLLECT, DISCARD, LAUNCH, WAIT, DRAIN} state_t;

  state_t              state, state_nx;
  logic [L:0]          count, idx, nout;
  logic                discard;
  logic [W-1:0]        buf_dist [N];
  logic [TYPE_W-1:0]   buf_type [N];
  logic [W-1:0]        res_dist [N];
  logic [TYPE_W-1:0]   res_type [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign sort_in[W*g +: W]                = buf_dist[g];
    assign sort_in_type[TYPE_W*g +: TYPE_W] = buf_type[g];
  end

  assign sort_ascending = 1'b1;
  assign busy = !(state == COLLECT && count == '0);
  // Padding is never emitted because at most count results are streamed.
  assign nout     = (count < (L+1)'(K)) ? count : (L+1)'(K);
  assign out_last = (state == DRAIN) && (idx == nout - 1'b1);
  assign out_dist = (state == DRAIN) ? res_dist[idx[L-1:0]] : '0;
  assign out_type = (state == DRAIN) ? res_type[idx[L-1:0]] : '0;

  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    sort_in_valid = 1'b0;
    out_valid     = 1'b0;
    trunc_err     = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last) begin
            state_nx = LAUNCH;
          end else if (count == (L+1)'(N-1)) begin
            state_nx  = LAUNCH;
            trunc_err = 1'b1;
          end
        end
      end
      DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = COLLECT;
      end
      LAUNCH: begin
        sort_in_valid = 1'b1;
        state_nx      = WAIT;
      end
      WAIT: begin
        if (sort_out_valid) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nx = discard ? DISCARD : COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      count   <= '0;
      idx     <= '0;
      discard <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        buf_dist[i] <= '1;
        buf_type[i] <= '0;
        res_dist[i] <= '0;
        res_type[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            buf_dist[count[L-1:0]] <= in_dist;
            buf_type[count[L-1:0]] <= in_type;
            count <= count + 1'b1;
            if (!in_last && count == (L+1)'(N-1)) discard <= 1'b1;
          end
        end
        DISCARD: begin
          if (in_valid && in_last) discard <= 1'b0;
        end
        WAIT: begin
          if (sort_out_valid) begin
            idx <= '0;
            for (int unsigned i = 0; i < N; i++) begin
              res_dist[i] <= sort_out[W*i +: W];
              res_type[i] <= sort_out_type[TYPE_W*i +: TYPE_W];
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            idx <= idx + 1'b1;
            if (out_last) begin
              count <= '0;
              for (int unsigned i = 0; i < N; i++) begin
                buf_dist[i] <= '1;
                buf_type[i] <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Self-checking bench for knn_sort_ctrl: acts as the sorter, predicts the K
// nearest results per frame from the accepted beats, and checks every cycle.
module tb_knn_sort_ctrl;

  localparam int L  = 3;
  localparam int W  = 16;
  localparam int TW = 3;
  localparam int K  = 3;
  localparam int N  = 1 << L;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [W-1:0] in_dist = '0;
  logic [TW-1:0] in_type = '0;
  logic sort_in_valid, sort_ascending;
  logic [W*N-1:0] sort_in, sort_out = '0;
  logic [TW*N-1:0] sort_in_type, sort_out_type = '0;
  logic sort_out_valid = 1'b0;
  logic out_valid, out_ready = 1'b1, out_last, trunc_err, busy;
  logic [W-1:0] out_dist;
  logic [TW-1:0] out_type;

  knn_sort_ctrl #(.L(L), .W(W), .TYPE_W(TW), .K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .in_type(in_type), .in_last(in_last),
    .sort_in_valid(sort_in_valid), .sort_ascending(sort_ascending),
    .sort_in(sort_in), .sort_in_type(sort_in_type),
    .sort_out(sort_out), .sort_out_type(sort_out_type),
    .sort_out_valid(sort_out_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .out_type(out_type), .out_last(out_last),
    .trunc_err(trunc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          last;
  } beat_t;

  int tests = 0;
  int fails = 0;
  beat_t frame_q[$], exp_q[$], got_q[$];
  bit m_discard = 0, launch_pending = 0, stall_prev = 0;
  bit hold_sorter = 0, rnd_ready = 0;
  int trunc_seen = 0;
  logic [W+TW:0] prev_out;

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the K smallest distances of the (truncated) frame, ties in arrival order.
  function automatic void finish_frame();
    beat_t a[$];
    beat_t tmp;
    int n;
    a = frame_q;
    for (int i = 1; i < a.size(); i++)
      for (int j = i; j > 0 && a[j-1].d > a[j].d; j--) begin
        tmp = a[j]; a[j] = a[j-1]; a[j-1] = tmp;
      end
    n = (a.size() < K) ? a.size() : K;
    for (int i = 0; i < n; i++) begin
      tmp = a[i];
      tmp.last = (i == n - 1);
      exp_q.push_back(tmp);
    end
    frame_q.delete();
  endfunction

  always @(negedge clk) begin
    beat_t b;
    bit exp_trunc;
    if (rst) begin
      frame_q.delete(); exp_q.delete();
      m_discard = 0; launch_pending = 0; stall_prev = 0;
    end else begin
      chk("sort_in_valid", sort_in_valid, launch_pending);
      launch_pending = 0;
      if (out_valid) begin
        if (stall_prev) chk("stall_hold", {out_dist, out_type, out_last}, prev_out);
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("out_dist", out_dist, exp_q[0].d);
          chk("out_type", out_type, exp_q[0].t);
          chk("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            b.d = out_dist; b.t = out_type; b.last = out_last;
            got_q.push_back(b);
            void'(exp_q.pop_front());
          end
        end
      end else if (stall_prev) chk("stall_drop", out_valid, 1);
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_dist, out_type, out_last};
      exp_trunc = 0;
      if (in_valid && in_ready) begin
        if (m_discard) begin
          if (in_last) m_discard = 0;
        end else begin
          b.d = in_dist; b.t = in_type; b.last = in_last;
          frame_q.push_back(b);
          if (in_last) begin
            finish_frame(); launch_pending = 1;
          end else if (frame_q.size() == N) begin
            finish_frame(); launch_pending = 1; m_discard = 1; exp_trunc = 1;
          end
        end
      end
      chk("trunc_err", trunc_err, exp_trunc);
      if (trunc_err) trunc_seen++;
    end
  end

  // Sorter stand-in: stable ascending sort, result after L cycles.
  initial forever begin
    logic [W-1:0]  d[N];
    logic [TW-1:0] t[N];
    logic [W-1:0]  td;
    logic [TW-1:0] tt;
    @(negedge clk);
    if (!rst && sort_in_valid && !hold_sorter) begin
      for (int i = 0; i < N; i++) begin
        d[i] = sort_in[W*i +: W];
        t[i] = sort_in_type[TW*i +: TW];
      end
      for (int i = 1; i < N; i++)
        for (int j = i; j > 0 && d[j-1] > d[j]; j--) begin
          td = d[j]; d[j] = d[j-1]; d[j-1] = td;
          tt = t[j]; t[j] = t[j-1]; t[j-1] = tt;
        end
      repeat (L) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        sort_out[W*i +: W]    = d[i];
        sort_out_type[TW*i +: TW] = t[i];
      end
      sort_out_valid = 1'b1;
      @(posedge clk); #1 sort_out_valid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(logic [W-1:0] d, logic [TW-1:0] t, logic last);
    int c = 0;
    in_valid = 1'b1; in_dist = d; in_type = t; in_last = last;
    do begin
      @(negedge clk); c++;
    end while (!in_ready && c < 300);
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge clk); c++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_got(string name, int i, logic [W-1:0] d, logic [TW-1:0] t, logic last);
    if (got_q.size() > i) chk(name, {got_q[i].d, got_q[i].t, got_q[i].last}, {d, t, last});
    else chk({name, "_missing"}, got_q.size(), i + 1);
  endtask

  initial begin
    logic [W*N-1:0] ones;
    int len;
    ones = '1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sort_in", sort_in, ones);
    chk("rst_sort_in_type", sort_in_type, 0);
    chk("rst_sort_in_valid", sort_in_valid, 0);
    chk("rst_ascending", sort_ascending, 1);
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    got_q.delete();
    send_beat(50, 1, 0); send_beat(10, 2, 0); send_beat(40, 3, 0);
    send_beat(30, 4, 0); send_beat(20, 5, 1);
    wait_drain();
    chk("f1_count", got_q.size(), 3);
    chk_got("f1_b0", 0, 10, 2, 0);
    chk_got("f1_b1", 1, 20, 5, 0);
    chk_got("f1_b2", 2, 30, 4, 1);

    got_q.delete();
    send_beat(7, 1, 0); send_beat(3, 2, 1);
    wait_drain();
    chk("f2_count", got_q.size(), 2);
    chk_got("f2_b0", 0, 3, 2, 0);
    chk_got("f2_b1", 1, 7, 1, 1);

    got_q.delete();
    trunc_seen = 0;
    for (int i = 0; i < 10; i++) send_beat(16'(90 - 10 * i), 3'(i), (i == 9));
    wait_drain();
    chk("ovf_trunc_count", trunc_seen, 1);
    chk("ovf_count", got_q.size(), 3);
    chk_got("ovf_b0", 0, 20, 7, 0);
    chk_got("ovf_b1", 1, 30, 6, 0);
    chk_got("ovf_b2", 2, 40, 5, 1);
    @(negedge clk);
    chk("ovf_idle_busy", busy, 0);
    @(posedge clk); #1;

    rnd_ready = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++)
        send_beat(16'($urandom_range(0, 16'hFFFE)), 3'($urandom_range(0, 7)), (i == len - 1));
      wait_drain();
      @(negedge clk);
      chk("rand_idle_busy", busy, 0);
      @(posedge clk); #1;
    end
    rnd_ready = 0;

    hold_sorter = 1;
    send_beat(5, 1, 0); send_beat(6, 2, 1);
    begin
      int c = 0;
      while (!sort_in_valid && c < 20) begin
        @(negedge clk); c++;
      end
      chk("rw_launch_seen", sort_in_valid, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sort_out = '0; sort_out_type = '0; sort_out_valid = 1'b1;
    @(posedge clk); #1 sort_out_valid = 1'b0;
    hold_sorter = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rw_out_valid", out_valid, 0);
      chk("rw_busy", busy, 0);
      chk("rw_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;

    got_q.delete();
    send_beat(9, 3, 0); send_beat(4, 6, 1);
    wait_drain();
    chk("post_count", got_q.size(), 2);
    chk_got("post_b0", 0, 4, 6, 0);
    chk_got("post_b1", 1, 9, 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
